// File: rtl/exec_issue_scheduler.sv
// exec_issue_scheduler: issues one of the integer / load-store / branch reservation stations to Execute per cycle.
// Defining ISSUE_PERF_CNT_EN builds the perf_issued / perf_stalled counters; otherwise both ports read zero.
module exec_issue_scheduler #(
    parameter int unsigned LS_LATENCY = 2,
    parameter logic [2:0]  IDLE_CODE  = 3'b000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        kill,
    input  logic        stall,
    input  logic        req_int,
    input  logic        req_ls,
    input  logic        req_branch,
    input  logic        branch_resolved,
    output logic        gnt_int,
    output logic        gnt_ls,
    output logic        gnt_branch,
    output logic        issue_valid,
    output logic [2:0]  rs_destination,
    output logic        ls_busy,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stalled
);
    localparam logic [2:0] RS_INTEGER    = 3'b001;
    localparam logic [2:0] RS_LOAD_STORE = 3'b010;
    localparam logic [2:0] RS_BRANCH     = 3'b100;
    localparam logic [0:0] ISSUE         = 1'b0;
    localparam logic [0:0] BR_WAIT       = 1'b1;
    localparam logic [3:0] LS_LOAD       = 4'(LS_LATENCY - 1);

    logic [0:0] state;
    logic       ptr_ls;
    logic [2:0] mask;
    logic [3:0] ls_cnt;
    logic       can_issue, elig_int, elig_ls, elig_br, pick_int, pick_ls, pick_br;

    assign ls_busy = ls_cnt != 4'd0;

    // mask holds last cycle's grant so a still-held request is not granted twice
    always_comb begin
        can_issue = state == ISSUE && !stall && !kill;
        elig_br   = req_branch && !mask[2];
        elig_ls   = req_ls && !mask[1] && !ls_busy;
        elig_int  = req_int && !mask[0];
        pick_br   = can_issue && elig_br;
        pick_int  = can_issue && !elig_br && elig_int && (!elig_ls || !ptr_ls);
        pick_ls   = can_issue && !elig_br && elig_ls && (!elig_int || ptr_ls);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ISSUE;
            ptr_ls         <= 1'b0;
            mask           <= '0;
            ls_cnt         <= '0;
            gnt_int        <= 1'b0;
            gnt_ls         <= 1'b0;
            gnt_branch     <= 1'b0;
            issue_valid    <= 1'b0;
            rs_destination <= IDLE_CODE;
        end else begin
            gnt_int        <= pick_int;
            gnt_ls         <= pick_ls;
            gnt_branch     <= pick_br;
            issue_valid    <= pick_int || pick_ls || pick_br;
            rs_destination <= pick_br ? RS_BRANCH : pick_ls ? RS_LOAD_STORE : pick_int ? RS_INTEGER : IDLE_CODE;
            if (kill || (state == BR_WAIT && branch_resolved))
                state <= ISSUE;
            else if (pick_br)
                state <= BR_WAIT;
            if (pick_int || pick_ls)
                ptr_ls <= pick_int;
            if (kill)
                mask <= '0;
            else if (!stall)
                mask <= {pick_br, pick_ls, pick_int};
            // an in-flight load/store keeps draining through a kill
            if (pick_ls)
                ls_cnt <= LS_LOAD;
            else if ((kill || !stall) && ls_busy)
                ls_cnt <= ls_cnt - 4'd1;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued  <= '0;
            perf_stalled <= '0;
        end else begin
            if (pick_int || pick_ls || pick_br)
                perf_issued <= perf_issued + 32'd1;
            if (stall || state == BR_WAIT)
                perf_stalled <= perf_stalled + 32'd1;
        end
    end
`else
    assign perf_issued  = 32'd0;
    assign perf_stalled = 32'd0;
`endif
endmodule

// File: tb/tb_exec_issue_scheduler.sv
// tb_exec_issue_scheduler: two schedulers (LS_LATENCY 1 and 3) on shared inputs, checked
// against a rule-level reference model, a directed vector table and hand-written sequences.
module tb_exec_issue_scheduler;
    logic clk = 1'b0, reset_n = 1'b0, kill = 1'b0, stall = 1'b0;
    logic req_int = 1'b0, req_ls = 1'b0, req_branch = 1'b0, branch_resolved = 1'b0;
    logic        d_gi[2], d_gl[2], d_gb[2], d_iv[2], d_busy[2];
    logic [2:0]  d_dest[2];
    logic [31:0] d_pi[2], d_ps[2];

    always #5 clk = ~clk;

    exec_issue_scheduler #(.LS_LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n), .kill(kill), .stall(stall), .req_int(req_int), .req_ls(req_ls),
        .req_branch(req_branch), .branch_resolved(branch_resolved), .gnt_int(d_gi[0]), .gnt_ls(d_gl[0]),
        .gnt_branch(d_gb[0]), .issue_valid(d_iv[0]), .rs_destination(d_dest[0]), .ls_busy(d_busy[0]),
        .perf_issued(d_pi[0]), .perf_stalled(d_ps[0]));

    exec_issue_scheduler #(.LS_LATENCY(3)) u3 (
        .clk(clk), .reset_n(reset_n), .kill(kill), .stall(stall), .req_int(req_int), .req_ls(req_ls),
        .req_branch(req_branch), .branch_resolved(branch_resolved), .gnt_int(d_gi[1]), .gnt_ls(d_gl[1]),
        .gnt_branch(d_gb[1]), .issue_valid(d_iv[1]), .rs_destination(d_dest[1]), .ls_busy(d_busy[1]),
        .perf_issued(d_pi[1]), .perf_stalled(d_ps[1]));

    int n_chk = 0, n_fail = 0;
    int m_lat[2] = '{1, 3};
    // m_g / m_last: unit granted (0 int, 1 ls, 2 branch, -1 none); m_left: load/store cycles still busy
    int m_g[2], m_last[2], m_left[2];
    bit m_bw[2], m_pls[2];
    int unsigned m_pi[2], m_ps[2];

    typedef struct {
        logic [5:0] in;
        logic [2:0] gnt;
        logic       busy;
    } vec_t;
    vec_t tbl[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_g[k] = -1; m_last[k] = -1; m_left[k] = 0;
            m_bw[k] = 1'b0; m_pls[k] = 1'b0; m_pi[k] = 0; m_ps[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit e_b, e_i, e_l;
        int g;
        g   = -1;
        e_b = req_branch && m_last[k] != 2;
        e_i = req_int && m_last[k] != 0;
        e_l = req_ls && m_last[k] != 1 && m_left[k] == 0;
        if (!kill && !stall && !m_bw[k]) begin
            if (e_b) g = 2;
            else if (e_i && e_l) g = m_pls[k] ? 1 : 0;
            else if (e_i) g = 0;
            else if (e_l) g = 1;
        end
        if (stall || m_bw[k]) m_ps[k]++;
        if (g >= 0) m_pi[k]++;
        if (g == 1) m_left[k] = m_lat[k] - 1;
        else if ((!stall || kill) && m_left[k] > 0) m_left[k]--;
        if (g == 0) m_pls[k] = 1'b1;
        if (g == 1) m_pls[k] = 1'b0;
        if (kill || (m_bw[k] && branch_resolved)) m_bw[k] = 1'b0;
        else if (g == 2) m_bw[k] = 1'b1;
        if (kill) m_last[k] = -1;
        else if (!stall) m_last[k] = g;
        m_g[k] = g;
    endtask

    function automatic logic [2:0] exp_dest(input int g);
        return g == 0 ? 3'b001 : g == 1 ? 3'b010 : g == 2 ? 3'b100 : 3'b000;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] epi, eps;
        for (int k = 0; k < 2; k++) begin
`ifdef ISSUE_PERF_CNT_EN
            epi = m_pi[k]; eps = m_ps[k];
`else
            epi = 32'd0; eps = 32'd0;
`endif
            chk($sformatf("%s L%0d gnt", tag, m_lat[k]), {29'd0, d_gb[k], d_gl[k], d_gi[k]},
                {29'd0, m_g[k] == 2, m_g[k] == 1, m_g[k] == 0});
            chk($sformatf("%s L%0d dest", tag, m_lat[k]), {29'd0, d_dest[k]}, {29'd0, exp_dest(m_g[k])});
            chk($sformatf("%s L%0d valid", tag, m_lat[k]), {31'd0, d_iv[k]}, {31'd0, m_g[k] >= 0});
            chk($sformatf("%s L%0d busy", tag, m_lat[k]), {31'd0, d_busy[k]}, {31'd0, m_left[k] > 0});
            chk($sformatf("%s L%0d perf_issued", tag, m_lat[k]), d_pi[k], epi);
            chk($sformatf("%s L%0d perf_stalled", tag, m_lat[k]), d_ps[k], eps);
        end
    endtask

    task automatic drive(input logic [5:0] v);
        {kill, stall, req_int, req_ls, req_branch, branch_resolved} = v;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!reset_n) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(6'b0);
        cycle("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        // inputs {kill, stall, req_int, req_ls, req_branch, branch_resolved}; expected {br, ls, int} and ls_busy of L3
        tbl[0]  = '{6'b001010, 3'b100, 1'b0};
        tbl[1]  = '{6'b001000, 3'b000, 1'b0};
        tbl[2]  = '{6'b001000, 3'b000, 1'b0};
        tbl[3]  = '{6'b001001, 3'b000, 1'b0};
        tbl[4]  = '{6'b001000, 3'b001, 1'b0};
        tbl[5]  = '{6'b000100, 3'b010, 1'b1};
        tbl[6]  = '{6'b000100, 3'b000, 1'b1};
        tbl[7]  = '{6'b000100, 3'b000, 1'b0};
        tbl[8]  = '{6'b000100, 3'b010, 1'b1};
        tbl[9]  = '{6'b010100, 3'b000, 1'b1};
        tbl[10] = '{6'b010100, 3'b000, 1'b1};
        tbl[11] = '{6'b010100, 3'b000, 1'b1};
        tbl[12] = '{6'b010100, 3'b000, 1'b1};
        tbl[13] = '{6'b000100, 3'b000, 1'b1};
        tbl[14] = '{6'b000100, 3'b000, 1'b0};
        tbl[15] = '{6'b000100, 3'b010, 1'b1};
        tbl[16] = '{6'b000010, 3'b100, 1'b1};
        tbl[17] = '{6'b101000, 3'b000, 1'b0};
        tbl[18] = '{6'b001000, 3'b001, 1'b0};
        tbl[19] = '{6'b000001, 3'b000, 1'b0};
        tbl[20] = '{6'b000010, 3'b100, 1'b0};
        tbl[21] = '{6'b010001, 3'b000, 1'b0};
        tbl[22] = '{6'b001000, 3'b001, 1'b0};

        model_reset();
        @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            cycle("tbl");
            chk($sformatf("tbl[%0d] L3 gnt", i), {29'd0, d_gb[1], d_gl[1], d_gi[1]}, {29'd0, tbl[i].gnt});
            chk($sformatf("tbl[%0d] L3 ls_busy", i), {31'd0, d_busy[1]}, {31'd0, tbl[i].busy});
        end

        // asynchronous reset in the middle of an int/ls burst
        drive(6'b001100);
        repeat (3) cycle("burst");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async rst L%0d grants", m_lat[k]), {28'd0, d_iv[k], d_gb[k], d_gl[k], d_gi[k]}, 32'd0);
            chk($sformatf("async rst L%0d dest", m_lat[k]), {29'd0, d_dest[k]}, 32'd0);
        end
        cycle("rst hold");
        reset_n = 1'b1;
        cycle("after rst 1");
        chk("after rst L1 gnt 1", {29'd0, d_gb[0], d_gl[0], d_gi[0]}, 32'b001);
        chk("after rst L1 dest 1", {29'd0, d_dest[0]}, 32'd1);
        cycle("after rst 2");
        chk("after rst L1 gnt 2", {29'd0, d_gb[0], d_gl[0], d_gi[0]}, 32'b010);
        chk("after rst L1 dest 2", {29'd0, d_dest[0]}, 32'd2);
        cycle("after rst 3");
        chk("after rst L1 gnt 3", {29'd0, d_gb[0], d_gl[0], d_gi[0]}, 32'b001);
        chk("after rst L1 dest 3", {29'd0, d_dest[0]}, 32'd1);

        // perf counters: 10 issues then 5 stall cycles on the LS_LATENCY=1 unit
        do_reset();
        drive(6'b001100);
        repeat (10) cycle("perf issue");
        drive(6'b011100);
        repeat (5) cycle("perf stall");
`ifdef ISSUE_PERF_CNT_EN
        chk("perf L1 issued=10", d_pi[0], 32'd10);
        chk("perf L1 stalled=5", d_ps[0], 32'd5);
`else
        chk("perf L1 issued tied 0", d_pi[0], 32'd0);
        chk("perf L1 stalled tied 0", d_ps[0], 32'd0);
`endif
        drive(6'b0);

        for (int n = 0; n < 1500; n++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            kill = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 5) == 0);
            req_int = $urandom_range(0, 1);
            req_ls = $urandom_range(0, 1);
            req_branch = ($urandom_range(0, 2) == 0);
            branch_resolved = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
